instruction_fetch: RTL

Fetch stage for the ARM-LP LEGv8 core. Sits directly upstream of the decoder/controller. Holds the program counter and issues one 32-bit instruction request at a time to the instruction cache. Buffers returned words in a small queue and presents them to decode with a valid/ready handshake. Branch resolution from the controller (`branch`, `unconditionalBranch`) plus the ALU zero flag redirects the PC, flushes the queue and squashes any in-flight fetch.

---
 rtl/arm_lp_pkg.sv | 15 +
 rtl/fetch_queue.sv | 96 +++++++++
 rtl/instruction_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/arm_lp_pkg.sv
// Shared ARM-LP core types and constants: address/instruction widths, fetch step, fetch FSM states.
// No logic of its own; no latency or backpressure.
package arm_lp_pkg;

    localparam int PC_WIDTH    = 64;
    localparam int INSTR_WIDTH = 32;
    localparam int INSTR_STEP  = 4;

    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction/PC FIFO with flush and registered head; data is visible one edge after push.
// The caller must not push when full; a pop of an empty queue is ignored.
module fetch_queue #(
    parameter int PC_WIDTH = arm_lp_pkg::PC_WIDTH,
    parameter int DEPTH    = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  i_push,
    input  logic [arm_lp_pkg::INSTR_WIDTH-1:0]    i_push_instr,
    input  logic [PC_WIDTH-1:0]                   i_push_pc,
    input  logic                                  i_pop,
    input  logic                                  i_flush,
    output logic [$clog2(DEPTH):0]                o_count,
    output logic                                  o_head_vld,
    output logic [arm_lp_pkg::INSTR_WIDTH-1:0]    o_head_instr,
    output logic [PC_WIDTH-1:0]                   o_head_pc
);
    import arm_lp_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [PC_WIDTH-1:0]    r_mem_pc    [DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_head_vld;
    logic [INSTR_WIDTH-1:0] r_head_instr;
    logic [PC_WIDTH-1:0]    r_head_pc;

    logic                   w_pop;
    logic [PTR_W-1:0]       w_rd_nxt;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [INSTR_WIDTH-1:0] w_head_instr;
    logic [PC_WIDTH-1:0]    w_head_pc;

    assign w_pop = i_pop && (r_count != '0);

    // The head register is loaded with whatever entry will sit at the read pointer after this edge.
    always_comb begin
        w_rd_nxt     = r_rd_ptr + PTR_W'(w_pop);
        w_count_nxt  = r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        w_head_instr = '0;
        w_head_pc    = '0;
        if (w_count_nxt != '0) begin
            if (i_push && (w_rd_nxt == r_wr_ptr)) begin
                w_head_instr = i_push_instr;
                w_head_pc    = i_push_pc;
            end else begin
                w_head_instr = r_mem_instr[w_rd_nxt];
                w_head_pc    = r_mem_pc[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_vld   <= 1'b0;
            r_head_instr <= '0;
            r_head_pc    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_vld   <= 1'b0;
            r_head_instr <= '0;
            r_head_pc    <= '0;
        end else begin
            if (i_push) begin
                r_mem_instr[r_wr_ptr] <= i_push_instr;
                r_mem_pc[r_wr_ptr]    <= i_push_pc;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr     <= w_rd_nxt;
            r_count      <= w_count_nxt;
            r_head_vld   <= (w_count_nxt != '0);
            r_head_instr <= w_head_instr;
            r_head_pc    <= w_head_pc;
        end
    end

    assign o_count      = r_count;
    assign o_head_vld   = r_head_vld;
    assign o_head_instr = r_head_instr;
    assign o_head_pc    = r_head_pc;

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC, single-outstanding icache request FSM, branch redirect; decode sees data 2 cycles after accept.
// Requests stop while the queue (including the in-flight slot) is full; decode stalls via instructionReady.
module instruction_fetch #(
    parameter int                  PC_WIDTH    = arm_lp_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  QUEUE_DEPTH = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic                               imemRequest,
    output logic [PC_WIDTH-1:0]                imemAddress,
    input  logic                               imemAccept,
    input  logic                               imemResponseValid,
    input  logic [arm_lp_pkg::INSTR_WIDTH-1:0] imemResponseData,
    output logic [arm_lp_pkg::INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]                instructionPC,
    output logic                               instructionValid,
    input  logic                               instructionReady,
    input  logic                               branch,
    input  logic                               unconditionalBranch,
    input  logic                               aluZero,
    input  logic [PC_WIDTH-1:0]                branchTarget
);
    import arm_lp_pkg::*;

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t       r_state;
    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] r_pending_pc;

    logic                w_redirect;
    logic [PC_WIDTH-1:0] w_target;
    logic [CNT_W-1:0]    w_count;
    logic                w_space;
    logic                w_request;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    assign w_redirect = unconditionalBranch | (branch & aluZero);
    assign w_target   = branchTarget & ~PC_WIDTH'(3);
    assign w_space    = (w_count < CNT_W'(QUEUE_DEPTH));

    // In ISSUE nothing is in flight, so a free queue slot is enough to guarantee room for the reply.
    assign w_request = !reset && (r_state == ST_ISSUE) && w_space && !w_redirect;
    assign w_accept  = w_request && imemAccept;
    assign w_push    = (r_state == ST_WAIT) && imemResponseValid && !w_redirect;
    assign w_pop     = instructionValid && instructionReady;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_ISSUE;
            r_fetch_pc   <= RESET_PC;
            r_pending_pc <= '0;
        end else if (w_redirect) begin
            r_fetch_pc <= w_target;
            // An outstanding reply that has not arrived yet must still be drained.
            if ((r_state == ST_ISSUE) || imemResponseValid) begin
                r_state <= ST_ISSUE;
            end else begin
                r_state <= ST_DISCARD;
            end
        end else begin
            case (r_state)
                ST_ISSUE: begin
                    if (w_accept) begin
                        r_pending_pc <= r_fetch_pc;
                        r_fetch_pc   <= r_fetch_pc + PC_WIDTH'(INSTR_STEP);
                        r_state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imemResponseValid) begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_DISCARD: begin
                    if (imemResponseValid) begin
                        r_state <= ST_ISSUE;
                    end
                end
                default: r_state <= ST_ISSUE;
            endcase
        end
    end

    fetch_queue #(
        .PC_WIDTH (PC_WIDTH),
        .DEPTH    (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clock        (clock),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_instr (imemResponseData),
        .i_push_pc    (r_pending_pc),
        .i_pop        (w_pop),
        .i_flush      (w_redirect),
        .o_count      (w_count),
        .o_head_vld   (instructionValid),
        .o_head_instr (instruction),
        .o_head_pc    (instructionPC)
    );

    assign imemRequest = w_request;
    assign imemAddress = r_fetch_pc;

endmodule
